// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------------+
// | cpu_pkg : shared types and default constants for the pipeline controller |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MUL_WAIT = 2'd2
  } stall_state_e;

  localparam int DEF_MUL_LATENCY    = 4;
  localparam int DEF_BRANCH_PENALTY = 2;
  localparam int DEF_STALL_CNT_W    = 16;

  // Sized for the largest legal MUL_LATENCY (15) and BRANCH_PENALTY (3)
  localparam int MUL_CNT_W   = 4;
  localparam int FLUSH_CNT_W = 2;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/stall_counter.sv
// +--------------------------------------------------------------------------+
// | stall_counter : saturating up-counter with enable and async active-low   |
// | clear. Rev 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module stall_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : stall_counter

`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
// +--------------------------------------------------------------------------+
// | pipeline_stall_controller : priority sequencer for PC / IF/ID / ID/EX /  |
// | EX/MEM enables, flushes and bubbles, plus a stall-cycle counter. Rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipeline_stall_controller
  import cpu_pkg::*;
#(
  parameter int MUL_LATENCY    = DEF_MUL_LATENCY,
  parameter int BRANCH_PENALTY = DEF_BRANCH_PENALTY,
  parameter int STALL_CNT_W    = DEF_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic                   loadUseHazard,
  input  logic                   branchTaken,
  input  logic                   mulStart,
  input  logic                   memBusy,
  output logic                   pcWrite,
  output logic                   ifIdWrite,
  output logic                   ifIdFlush,
  output logic                   idExWrite,
  output logic                   idExBubble,
  output logic                   exMemWrite,
  output logic                   exMemBubble,
  output logic                   mulDone,
  output logic [STALL_CNT_W-1:0] stallCycles
);

  localparam logic [MUL_CNT_W-1:0]   MUL_INIT   = MUL_CNT_W'(MUL_LATENCY - 2);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(BRANCH_PENALTY - 1);

  stall_state_e           state_q, state_d;
  logic [MUL_CNT_W-1:0]   mulCnt_q, mulCnt_d;
  logic [FLUSH_CNT_W-1:0] flushCnt_q, flushCnt_d;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= RUN;
      mulCnt_q   <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mulCnt_q   <= mulCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mulCnt_d    = mulCnt_q;
    flushCnt_d  = flushCnt_q;
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExWrite   = 1'b1;
    idExBubble  = 1'b0;
    exMemWrite  = 1'b1;
    exMemBubble = 1'b0;
    mulDone     = 1'b0;

    if (memBusy) begin
      // Whole pipeline frozen; every piece of sequencer state holds.
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemWrite = 1'b0;
    end else if (state_q == MUL_WAIT) begin
      if (mulCnt_q == '0) begin
        mulDone = 1'b1;
        state_d = RUN;
      end else begin
        pcWrite     = 1'b0;
        ifIdWrite   = 1'b0;
        idExWrite   = 1'b0;
        exMemBubble = 1'b1;
        mulCnt_d    = mulCnt_q - {{(MUL_CNT_W-1){1'b0}}, 1'b1};
      end
    end else if (branchTaken) begin
      ifIdFlush  = 1'b1;
      idExBubble = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        state_d    = FLUSH;
        flushCnt_d = FLUSH_INIT;
      end else begin
        state_d = RUN;
      end
    end else if (mulStart) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      exMemBubble = 1'b1;
      state_d     = MUL_WAIT;
      mulCnt_d    = MUL_INIT;
    end else if (state_q == FLUSH) begin
      ifIdFlush  = 1'b1;
      flushCnt_d = flushCnt_q - {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
      if (flushCnt_q == {{(FLUSH_CNT_W-1){1'b0}}, 1'b1}) begin
        state_d = RUN;
      end
    end else if (loadUseHazard) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExBubble = 1'b1;
    end
  end

  stall_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_counter (
    .clk     (clk),
    .rstN    (rstN),
    .en_i    (~pcWrite),
    .count_o (stallCycles)
  );

endmodule : pipeline_stall_controller

`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
// +--------------------------------------------------------------------------+
// | tb_pipeline_stall_controller : directed stimulus with a queued scoreboard |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipeline_stall_controller;

  localparam int ML = 4;
  localparam int BP = 2;
  localparam int W  = 4;

  // Control vector order: pc, ifIdW, ifIdF, idExW, idExB, exMemW, exMemB, mulDone
  localparam logic [7:0] C_NORM = 8'b1101_0100;
  localparam logic [7:0] C_LU   = 8'b0001_1100;
  localparam logic [7:0] C_BR   = 8'b1111_1100;
  localparam logic [7:0] C_FL   = 8'b1111_0100;
  localparam logic [7:0] C_MUL  = 8'b0000_0110;
  localparam logic [7:0] C_DONE = 8'b1101_0101;
  localparam logic [7:0] C_MB   = 8'b0000_0000;

  // Input vector order: loadUse, branch, mulStart, memBusy
  localparam logic [3:0] I_NONE = 4'b0000;
  localparam logic [3:0] I_LU   = 4'b1000;
  localparam logic [3:0] I_BR   = 4'b0100;
  localparam logic [3:0] I_MS   = 4'b0010;
  localparam logic [3:0] I_MB   = 4'b0001;

  typedef struct {
    logic [7:0]   ctl;
    logic [W-1:0] st;
    int           step;
  } exp_t;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic loadUseHazard = 1'b0, branchTaken = 1'b0, mulStart = 1'b0, memBusy = 1'b0;
  logic pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble;
  logic exMemWrite, exMemBubble, mulDone;
  logic [W-1:0] stallCycles;

  exp_t   sb_q[$];
  int     checks = 0;
  int     failures = 0;
  int     step = 0;
  logic [W-1:0] exp_stall = '0;
  logic   prev_done = 1'b0;
  logic   mon_en = 1'b0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(
    .MUL_LATENCY    (ML),
    .BRANCH_PENALTY (BP),
    .STALL_CNT_W    (W)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .loadUseHazard (loadUseHazard),
    .branchTaken   (branchTaken),
    .mulStart      (mulStart),
    .memBusy       (memBusy),
    .pcWrite       (pcWrite),
    .ifIdWrite     (ifIdWrite),
    .ifIdFlush     (ifIdFlush),
    .idExWrite     (idExWrite),
    .idExBubble    (idExBubble),
    .exMemWrite    (exMemWrite),
    .exMemBubble   (exMemBubble),
    .mulDone       (mulDone),
    .stallCycles   (stallCycles)
  );

  // Drive one cycle of inputs and queue the hand-derived control response;
  // the expected counter is the count accumulated before this cycle.
  task automatic apply(input logic rst_v, input logic [3:0] in_v, input logic [7:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    rstN          = rst_v;
    loadUseHazard = in_v[3];
    branchTaken   = in_v[2];
    mulStart      = in_v[1];
    memBusy       = in_v[0];
    if (!rst_v) exp_stall = '0;
    e.ctl  = ctl;
    e.st   = exp_stall;
    e.step = step;
    sb_q.push_back(e);
    step++;
    if (rst_v && !ctl[7] && (exp_stall != {W{1'b1}})) exp_stall = exp_stall + 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act;
    act = {pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExBubble, exMemWrite, exMemBubble, mulDone};
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctl step=%0d actual=%b required=%b", e.step, act, e.ctl);
      end
      checks++;
      if (stallCycles !== e.st) begin
        failures++;
        $display("FAIL stallCycles step=%0d actual=%0d required=%0d", e.step, stallCycles, e.st);
      end
    end
    if (mon_en) begin
      checks++;
      if (!ifIdWrite && pcWrite) begin
        failures++;
        $display("FAIL inv_ifid_pc actual ifIdWrite=%b pcWrite=%b required pcWrite=0", ifIdWrite, pcWrite);
      end
      checks++;
      if (ifIdFlush && !ifIdWrite) begin
        failures++;
        $display("FAIL inv_flush_write actual ifIdFlush=%b ifIdWrite=%b required not both", ifIdFlush, ifIdWrite);
      end
      checks++;
      if (prev_done && mulDone) begin
        failures++;
        $display("FAIL inv_muldone_twice actual=1,1 required no consecutive pulses");
      end
    end
    prev_done = mulDone;
  end

  initial begin
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    apply(1'b0, I_NONE, C_NORM);          // in reset: RUN decode, counter clear
    apply(1'b1, I_NONE, C_NORM);
    apply(1'b1, I_LU,   C_LU);
    apply(1'b1, I_NONE, C_NORM);          // stall count now 1
    apply(1'b1, I_BR | I_LU, C_BR);       // load-use squashed by branch
    apply(1'b1, I_NONE, C_FL);
    apply(1'b1, I_NONE, C_NORM);
    apply(1'b1, I_MS,   C_MUL);
    apply(1'b1, I_NONE, C_MUL);
    apply(1'b1, I_NONE, C_MUL);
    apply(1'b1, I_NONE, C_DONE);          // 4th cycle of the op
    apply(1'b1, I_NONE, C_NORM);
    apply(1'b1, I_MS,   C_MUL);
    apply(1'b1, I_MS | I_BR, C_MUL);      // ignored in MUL_WAIT
    apply(1'b1, I_MB,   C_MB);            // mulCnt held at 1
    apply(1'b1, I_MB,   C_MB);
    apply(1'b1, I_NONE, C_MUL);
    apply(1'b1, I_NONE, C_DONE);
    apply(1'b1, I_NONE, C_NORM);
    apply(1'b1, I_BR,   C_BR);
    apply(1'b1, I_BR,   C_BR);            // flush restarts
    apply(1'b1, I_LU,   C_FL);            // load-use ignored in FLUSH
    apply(1'b1, I_MB | I_BR, C_MB);
    apply(1'b1, I_NONE, C_NORM);
    apply(1'b1, I_MS,   C_MUL);
    apply(1'b1, I_NONE, C_MUL);
    apply(1'b0, I_NONE, C_NORM);          // reset mid-MUL_WAIT
    apply(1'b1, I_NONE, C_NORM);
    apply(1'b1, I_NONE, C_NORM);
    apply(1'b1, I_NONE, C_NORM);
    for (int i = 0; i < 18; i++) apply(1'b1, I_LU, C_LU);   // drive counter into saturation
    apply(1'b1, I_NONE, C_NORM);
    apply(1'b1, I_MB,   C_MB);
    apply(1'b1, I_NONE, C_NORM);
    @(posedge clk);
    #1;
    loadUseHazard = 1'b0; branchTaken = 1'b0; mulStart = 1'b0; memBusy = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipeline_stall_controller

`default_nettype wire

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for all pipeline stage-enable, flush and bubble controls in the 5-stage core.
- Inputs:
  - load-use indication from HazardDetection (its bubbleInstruction output)
  - taken-branch resolution from EX
  - multi-cycle ALU start
  - data-memory busy
- Priority-resolves these inputs and drives PC, IF/ID, ID/EX and EX/MEM write/flush/bubble controls.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MUL_LATENCY, 4, EX cycles taken by a multi-cycle ALU op (legal range 2..15).
- BRANCH_PENALTY, 2, cycles IF/ID is flushed after a taken branch (legal range 1..3).
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  input  1  core clock; all state changes on rising edge
- rstN  input  1  asynchronous active-low reset
- loadUseHazard  input  1  load-use stall request from HazardDetection
- branchTaken  input  1  branch in EX resolved taken; PC target valid this cycle
- mulStart  input  1  multi-cycle ALU op entering EX this cycle
- memBusy  input  1  data memory not ready; freezes the whole pipeline
- pcWrite  output  1  PC register write enable
- ifIdWrite  output  1  IF/ID register write enable
- ifIdFlush  output  1  IF/ID loads a NOP
- idExWrite  output  1  ID/EX register write enable
- idExBubble  output  1  ID/EX loads control zeros
- exMemWrite  output  1  EX/MEM register write enable
- exMemBubble  output  1  EX/MEM loads control zeros
- mulDone  output  1  one-cycle pulse when a multi-cycle op completes
- stallCycles  output  STALL_CNT_W  saturating count of cycles with pcWrite=0

Behaviour:
- Reset (rstN low, async):
  - state=RUN, mulCnt=0, flushCnt=0, stallCycles=0.
  - Outputs then follow RUN decode with current inputs.
- Outputs are combinational from registered state plus current inputs. State and counters update on the clk rising edge.
- Priority, highest first: memBusy > MUL_WAIT state > branchTaken > mulStart > FLUSH state > loadUseHazard.
- memBusy=1, any state:
  - Outputs: all *Write=0, all flush/bubble=0, mulDone=0.
  - State, mulCnt and flushCnt hold.
  - stallCycles increments.
- RUN, no requests: all *Write=1, flush/bubble=0.
- RUN + loadUseHazard only:
  - Outputs: pcWrite=0, ifIdWrite=0, idExBubble=1, idExWrite=1, exMemWrite=1.
  - State stays RUN; the stall lasts exactly as long as the input is asserted.
- RUN + branchTaken:
  - Outputs: pcWrite=1, ifIdFlush=1, idExBubble=1.
  - If BRANCH_PENALTY>1: state goes to FLUSH with flushCnt=BRANCH_PENALTY-1.
  - loadUseHazard and mulStart are ignored in the same cycle (the younger instruction is squashed).
- FLUSH:
  - Outputs: pcWrite=1, ifIdFlush=1, idExBubble=0.
  - flushCnt decrements; at flushCnt==1 the next state is RUN.
  - branchTaken in FLUSH restarts the flush with flushCnt=BRANCH_PENALTY-1.
  - loadUseHazard is ignored in FLUSH.
- RUN + mulStart:
  - Outputs this cycle: pcWrite=0, ifIdWrite=0, idExWrite=0, exMemBubble=1.
  - Next state is MUL_WAIT with mulCnt=MUL_LATENCY-2.
- MUL_WAIT:
  - Outputs: same freeze as the mulStart cycle.
  - mulCnt decrements each cycle.
  - When mulCnt==0: mulDone=1 and all enables=1 this cycle (the result latches into EX/MEM); next state is RUN.
  - mulStart and branchTaken are ignored while in MUL_WAIT.
- Total EX occupancy of a multi-cycle op = MUL_LATENCY cycles, including the mulStart cycle.
- stallCycles:
  - Increments on every cycle with pcWrite=0.
  - Saturates at all-ones; no wrap-around.
- Reset mid-MUL_WAIT or mid-FLUSH: returns to RUN immediately; no mulDone pulse.
- Invariants (bench asserts):
  - ifIdWrite==0 implies pcWrite==0.
  - ifIdFlush and ifIdWrite=0 are never asserted together.
  - mulDone is never high for 2 consecutive cycles.

Decomposition:
- Shared package (cpu_pkg): state enum {RUN, FLUSH, MUL_WAIT} and default parameter constants.
- One natural sub-module: stall_counter (saturating up-counter with enable, async active-low clear), reusable for other performance counters.

Test Plan:
- Release rstN with no requests → pcWrite=ifIdWrite=idExWrite=exMemWrite=1, stallCycles=0.
- loadUseHazard=1 for 1 cycle → that cycle pcWrite=0, ifIdWrite=0, idExBubble=1; next cycle all enables=1; stallCycles=1.
- branchTaken=1 with BRANCH_PENALTY=2 and loadUseHazard=1 in the same cycle → ifIdFlush=1 for 2 consecutive cycles, idExBubble=1 only in the first, pcWrite=1 throughout.
- mulStart=1 with MUL_LATENCY=4 → pcWrite=0 for 3 cycles, mulDone pulses in cycle 4, stallCycles=3.
- memBusy=1 for 2 cycles during MUL_WAIT (mulCnt=1) → all enables 0, mulCnt holds at 1; mulDone arrives 2 cycles later than in the memBusy-free case.
- rstN low mid-MUL_WAIT → immediate RUN, mulDone never pulses; preload stallCycles near max (or drive with STALL_CNT_W=4) → holds at 15.
